// File: rtl/lc3_mar_mdr_unit.sv
// LC-3 MARMUX / MAR / MDR datapath with memory request FSM; mem_r pulses 2 cycles after mio_en plus memory wait cycles.
// Backpressure: mem_req holds until mem_ready; MAR/MDR loads are locked out while busy. Optional LC3_MEM_TIMEOUT_EN adds the access timeout.
module lc3_mar_mdr_unit #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int VEC_W    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ir,
    input  logic [ADDR_W-1:0] addr_sum,
    input  logic              marmux_sel,
    input  logic              gate_marmux,
    input  logic              gate_mdr,
    input  logic [DATA_W-1:0] bus_in,
    output tri logic [DATA_W-1:0] main_bus,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              mio_en,
    input  logic              r_w,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
`ifdef LC3_MEM_TIMEOUT_EN
    output logic              mem_timeout,
`endif
    output logic              mem_r,
    output logic              busy,
    output logic              bus_conflict
);
    localparam int MW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              req_q, we_q, r_q;
    logic              expire;

    // Widen through MW so both narrower and wider address buses map cleanly.
    logic [ADDR_W-1:0] marmux_val;
    logic [MW-1:0]     marmux_wide, bus_in_wide;
    logic [DATA_W-1:0] marmux_bus;
    logic              unused_bits;

    assign marmux_val  = marmux_sel ? addr_sum : ADDR_W'(ir[VEC_W-1:0]);
    assign marmux_wide = MW'(marmux_val);
    assign marmux_bus  = marmux_wide[DATA_W-1:0];
    assign bus_in_wide = MW'(bus_in);
    assign unused_bits = ^{ir, marmux_wide, bus_in_wide};

    assign bus_conflict = gate_marmux & gate_mdr;
    assign main_bus     = (gate_marmux ^ gate_mdr) ? (gate_marmux ? marmux_bus : mdr_q)
                                                   : {DATA_W{1'bz}};

    assign busy      = (state_q != IDLE);
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_r     = r_q;

    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        if (!busy && ld_mar) mar_d = bus_in_wide[ADDR_W-1:0];
        if (state_q == ACCESS && mem_ready && !we_q) mdr_d = mem_rdata;
        else if (!busy && ld_mdr)                    mdr_d = bus_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end

`ifdef LC3_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    // The WAIT_MAX-th ACCESS cycle is the one that sees cnt_q == WAIT_MAX-1.
    assign expire      = (cnt_q == CNT_W'(WAIT_MAX - 1));
    assign mem_timeout = timeout_q;
`else
    localparam int UNUSED_WAIT = WAIT_MAX;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            r_q     <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            r_q <= 1'b0;
            case (state_q)
                IDLE: if (mio_en) begin
                    state_q <= ACCESS;
                    req_q   <= 1'b1;
                    we_q    <= r_w;
`ifdef LC3_MEM_TIMEOUT_EN
                    cnt_q     <= '0;
                    timeout_q <= 1'b0;
`endif
                end
                ACCESS: begin
                    if (mem_ready || expire) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        r_q     <= 1'b1;
                    end
`ifdef LC3_MEM_TIMEOUT_EN
                    if (!mem_ready && expire) timeout_q <= 1'b1;
                    cnt_q <= cnt_q + CNT_W'(1);
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3_mar_mdr_unit.sv
// Directed bench for lc3_mar_mdr_unit with a transaction-level reference model and per-cycle compare.
module tb_lc3_mar_mdr_unit;
    localparam int TB_WAIT = 4;
`ifdef LC3_MEM_TIMEOUT_EN
    localparam bit HAS_TO = 1'b1;
`else
    localparam bit HAS_TO = 1'b0;
`endif

    logic        clk, rst_n;
    logic [15:0] ir, addr_sum, bus_in, mem_rdata;
    logic        marmux_sel, gate_marmux, gate_mdr, ld_mar, ld_mdr, mio_en, r_w, mem_ready;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_req, mem_we, mem_r, busy, bus_conflict;
    logic        mem_timeout;
    tri   [15:0] main_bus_w;

    // When no gate is expected to drive, the bench holds the bus at zero; any stray DUT drive shows up.
    assign main_bus_w = (gate_marmux == gate_mdr) ? 16'h0000 : 16'hzzzz;

    lc3_mar_mdr_unit #(.ADDR_W(16), .DATA_W(16), .VEC_W(8), .WAIT_MAX(TB_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .addr_sum(addr_sum), .marmux_sel(marmux_sel),
        .gate_marmux(gate_marmux), .gate_mdr(gate_mdr), .bus_in(bus_in), .main_bus(main_bus_w),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .mio_en(mio_en), .r_w(r_w),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
`ifdef LC3_MEM_TIMEOUT_EN
        .mem_timeout(mem_timeout),
`endif
        .mem_r(mem_r), .busy(busy), .bus_conflict(bus_conflict)
    );
`ifndef LC3_MEM_TIMEOUT_EN
    assign mem_timeout = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, r_pulses = 0, base;
    bit chk_en = 1'b0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one memory transaction at a time, described as "waiting" then "completed".
    logic [15:0] m_mar, m_mdr;
    bit          m_waiting, m_completed, m_write, m_to, m_quiet;
    int          m_waited;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mar = 0; m_mdr = 0; m_waiting = 0; m_completed = 0; m_to = 0; m_write = 0; m_waited = 0;
        end else begin
            m_quiet = !m_waiting && !m_completed;
            if (m_quiet && ld_mar) m_mar = bus_in;
            if (m_quiet && ld_mdr) m_mdr = bus_in;
            if (m_completed) m_completed = 0;
            else if (m_waiting) begin
                m_waited = m_waited + 1;
                if (mem_ready) begin
                    if (!m_write) m_mdr = mem_rdata;
                    m_waiting = 0; m_completed = 1;
                end else if (HAS_TO && m_waited == TB_WAIT) begin
                    m_waiting = 0; m_completed = 1; m_to = 1;
                end
            end else if (mio_en) begin
                m_waiting = 1; m_write = r_w; m_waited = 0; m_to = 0;
            end
        end
    end

    function automatic logic [15:0] exp_bus();
        if (gate_marmux && !gate_mdr) return marmux_sel ? addr_sum : (ir & 16'h00FF);
        if (gate_mdr && !gate_marmux) return m_mdr;
        return 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("mem_req", mem_req, m_waiting);
            chk1("busy", busy, m_waiting || m_completed);
            chk1("mem_r", mem_r, m_completed);
            chk16("mem_addr", mem_addr, m_mar);
            chk16("mem_wdata", mem_wdata, m_mdr);
            if (m_waiting) chk1("mem_we", mem_we, m_write);
            chk1("bus_conflict", bus_conflict, gate_marmux && gate_mdr);
            chk16("main_bus", main_bus_w, exp_bus());
            if (HAS_TO) chk1("mem_timeout", mem_timeout, m_to);
            if (mem_r) r_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 0; ir = 0; addr_sum = 0; bus_in = 0; mem_rdata = 0; marmux_sel = 0;
        gate_marmux = 0; gate_mdr = 0; ld_mar = 0; ld_mdr = 0; mio_en = 0; r_w = 0; mem_ready = 0;
        tick();
        chk_en = 1;
        tick();
        rst_n = 1;
        settle();
        chk16("reset mar", mem_addr, 16'h0000);
        chk16("reset mdr", mem_wdata, 16'h0000);
        chk1("reset busy", busy, 1'b0);

        // MARMUX vector and adder paths
        ir = 16'hF025; marmux_sel = 0; gate_marmux = 1;
        settle();
        chk16("vector bus", main_bus_w, 16'h0025);
        marmux_sel = 1; addr_sum = 16'h3050;
        settle();
        chk16("adder bus", main_bus_w, 16'h3050);
        tick();

        // Read with 3 wait cycles
        gate_marmux = 0; bus_in = 16'h4000; ld_mar = 1;
        tick();
        ld_mar = 0; mio_en = 1; r_w = 0; base = r_pulses;
        tick();
        mio_en = 0; mem_rdata = 16'hBEEF;
        settle();
        chk16("read addr", mem_addr, 16'h4000);
        tick(); tick(); tick();
        mem_ready = 1;
        tick();
        mem_ready = 0;
        settle();
        chk1("read mem_r", mem_r, 1'b1);
        chk16("read mdr", mem_wdata, 16'hBEEF);
        tick();
        chk1("read mem_r drop", mem_r, 1'b0);
        chk16("read pulses", 16'(r_pulses - base), 16'd1);
        gate_mdr = 1;
        settle();
        chk16("mdr bus", main_bus_w, 16'hBEEF);
        tick();

        // Write with MAR/MDR load attempts during the access; stray mem_ready while idle
        gate_mdr = 0; bus_in = 16'h1234; ld_mdr = 1; mem_ready = 1;
        tick();
        ld_mdr = 0; mem_ready = 0; r_w = 1; mio_en = 1;
        tick();
        mio_en = 0; ld_mar = 1; ld_mdr = 1; bus_in = 16'hAAAA;
        settle();
        chk1("write we", mem_we, 1'b1);
        chk16("write wdata", mem_wdata, 16'h1234);
        tick();
        chk16("interlock mar", mem_addr, 16'h4000);
        chk16("interlock mdr", mem_wdata, 16'h1234);
        mem_ready = 1;
        tick();
        ld_mar = 0; ld_mdr = 0; mem_ready = 0;
        tick();
        chk16("write mdr after", mem_wdata, 16'h1234);

        // Read completion beats ld_mdr; double gate
        r_w = 0; mio_en = 1;
        tick();
        mio_en = 0; ld_mdr = 1; bus_in = 16'h5555; mem_ready = 1; mem_rdata = 16'h0F0F;
        tick();
        ld_mdr = 0; mem_ready = 0;
        settle();
        chk16("rdata wins", mem_wdata, 16'h0F0F);
        tick();
        gate_marmux = 1; gate_mdr = 1;
        settle();
        chk1("conflict flag", bus_conflict, 1'b1);
        chk16("conflict bus", main_bus_w, 16'h0000);
        tick();
        gate_marmux = 0; gate_mdr = 0;

        // Back-to-back accesses with mio_en held
        base = r_pulses; mio_en = 1; mem_ready = 1; mem_rdata = 16'h7777;
        for (int i = 0; i < 9; i++) tick();
        mio_en = 0; mem_ready = 0;
        chk16("streaming pulses", 16'(r_pulses - base), 16'd3);

        // Reset in the middle of an access
        mio_en = 1;
        tick();
        mio_en = 0; rst_n = 0;
        tick();
        rst_n = 1;
        settle();
        chk1("midreset req", mem_req, 1'b0);
        chk1("midreset busy", busy, 1'b0);
        chk16("midreset mar", mem_addr, 16'h0000);
        chk16("midreset mdr", mem_wdata, 16'h0000);
        chk16("midreset bus", main_bus_w, 16'h0000);
        tick();

`ifdef LC3_MEM_TIMEOUT_EN
        r_w = 0; mio_en = 1; mem_rdata = 16'hDEAD;
        tick();
        mio_en = 0;
        for (int i = 0; i < TB_WAIT; i++) tick();
        chk1("timeout mem_r", mem_r, 1'b1);
        chk1("timeout flag", mem_timeout, 1'b1);
        chk16("timeout mdr", mem_wdata, 16'h0000);
        tick(); tick();
        chk1("timeout sticky", mem_timeout, 1'b1);
        mio_en = 1;
        tick();
        mio_en = 0;
        chk1("timeout clear", mem_timeout, 1'b0);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        tick();
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
